// File: rtl/apb_slave_regfile.sv
// APB slave register file: NUM_REGS read/write 16-bit registers, a read-only ID
// word at address 4'hF, and a fixed number of access-phase wait states.
module apb_slave_regfile #(
   parameter int unsigned NUM_REGS    = 12,
   parameter int unsigned WAIT_CYCLES = 0,
   parameter logic [15:0] ID_VALUE    = 16'hA5B0
) (
   input  logic        pclk,
   input  logic        preset,
   input  logic        pselx,
   input  logic        penable,
   input  logic [3:0]  paddr,
   input  logic        pwrite,
   input  logic [15:0] pwdata,
   output logic        pready,
   output logic [15:0] prdata,
   output logic        pslverr
);

   // state   | meaning
   // S_IDLE  | no transfer; waiting for a setup phase
   // S_WAIT  | access phase with pready low; counter holds remaining wait cycles
   // S_READY | pready high; the next access edge completes the transfer
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_READY = 2'd2
   } state_t;

   localparam logic [4:0] NUM_REGS_W = 5'(NUM_REGS);
   localparam logic [3:0] WAIT_INIT  = 4'(WAIT_CYCLES);
   localparam logic [3:0] ID_ADDR    = 4'hF;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  addr_q, addr_d;
   logic        write_q, write_d;
   logic [15:0] wdata_q, wdata_d;
   logic        pready_q, pready_d;
   logic [15:0] prdata_q, prdata_d;
   logic        pslverr_q, pslverr_d;

   logic [15:0] regs_q [NUM_REGS];

   logic        setup;
   logic        access;
   logic        start;
   logic        resp_en;
   logic        commit;
   logic [3:0]  dec_addr;
   logic        dec_write;
   logic [15:0] rdata_dec;
   logic        err_dec;

   assign setup  = pselx && !penable;
   assign access = pselx && penable;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      write_d = write_q;
      wdata_d = wdata_q;
      start   = 1'b0;
      resp_en = 1'b0;
      commit  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (setup) start = 1'b1;
         end
         S_WAIT: begin
            if (!pselx) begin
               state_d = S_IDLE;
            end else if (access && (cnt_q != 4'd0)) begin
               cnt_d = cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_d = S_READY;
                  resp_en = 1'b1;
               end
            end
         end
         S_READY: begin
            if (access) begin
               commit  = 1'b1;
               state_d = S_IDLE;
            end else if (setup) begin
               start = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (start) begin
         addr_d  = paddr;
         write_d = pwrite;
         wdata_d = pwdata;
         if (WAIT_CYCLES == 0) begin
            state_d = S_READY;
            resp_en = 1'b1;
         end else begin
            cnt_d   = WAIT_INIT;
            state_d = S_WAIT;
         end
      end
   end

   // A zero-wait response is formed in the setup edge, before the latch holds the address.
   assign dec_addr  = start ? paddr  : addr_q;
   assign dec_write = start ? pwrite : write_q;

   always_comb begin
      rdata_dec = '0;
      err_dec   = 1'b0;
      if (dec_addr == ID_ADDR) begin
         err_dec = dec_write;
         if (!dec_write) rdata_dec = ID_VALUE;
      end else if ({1'b0, dec_addr} < NUM_REGS_W) begin
         if (!dec_write) rdata_dec = regs_q[dec_addr];
      end else begin
         err_dec = 1'b1;
      end
   end

   always_comb begin
      pready_d  = resp_en;
      prdata_d  = resp_en ? rdata_dec : 16'h0000;
      pslverr_d = resp_en ? err_dec : 1'b0;
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
         pready_q  <= 1'b0;
         prdata_q  <= '0;
         pslverr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         write_q   <= write_d;
         wdata_q   <= wdata_d;
         pready_q  <= pready_d;
         prdata_q  <= prdata_d;
         pslverr_q <= pslverr_d;
      end
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      end else if (commit && write_q && ({1'b0, addr_q} < NUM_REGS_W)) begin
         regs_q[addr_q] <= wdata_q;
      end
   end

   assign pready  = pready_q;
   assign prdata  = prdata_q;
   assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: three instances (0, 2 and 3 wait states) on a shared bus,
// directed vector table, hand-written abort/reset sequences, then random traffic vs a model.
module tb_apb_slave_regfile;

   logic        pclk = 1'b0;
   logic        preset;
   logic [2:0]  psel_v;
   logic        penable;
   logic [3:0]  paddr;
   logic        pwrite;
   logic [15:0] pwdata;
   logic [2:0]  pready_w;
   logic [15:0] prdata_w [3];
   logic [2:0]  pslverr_w;

   always #5 pclk = ~pclk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      apb_slave_regfile #(
         .NUM_REGS   (12),
         .WAIT_CYCLES((g == 0) ? 0 : ((g == 1) ? 2 : 3)),
         .ID_VALUE   (16'hA5B0)
      ) u_dut (
         .pclk   (pclk),
         .preset (preset),
         .pselx  (psel_v[g]),
         .penable(penable),
         .paddr  (paddr),
         .pwrite (pwrite),
         .pwdata (pwdata),
         .pready (pready_w[g]),
         .prdata (prdata_w[g]),
         .pslverr(pslverr_w[g])
      );
   end

   int n_cmp = 0;
   int n_bad = 0;
   logic [15:0] mem [3][16];

   typedef struct {
      int          inst;
      logic [3:0]  a;
      logic        w;
      logic [15:0] d;
      logic [15:0] rd;
      logic        er;
      int          wt;
      bit          b2b;
   } vec_t;

   vec_t tbl [18];

   function automatic int wait_of(input int inst);
      return (inst == 0) ? 0 : ((inst == 1) ? 2 : 3);
   endfunction

   function automatic logic [17:0] outs(input int inst);
      return {pready_w[inst], prdata_w[inst], pslverr_w[inst]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: address map rules applied directly to a per-instance array.
   task automatic model_xfer(input int inst, input logic [3:0] a, input logic w, input logic [15:0] d,
                             output logic [15:0] rd, output logic er);
      rd = 16'h0;
      er = 1'b0;
      if (a == 4'hF) begin
         if (w) er = 1'b1;
         else   rd = 16'hA5B0;
      end else if (a < 4'd12) begin
         if (w) mem[inst][a] = d;
         else   rd = mem[inst][a];
      end else begin
         er = 1'b1;
      end
   endtask

   task automatic idle_chk(input int inst, input string name);
      @(negedge pclk);
      psel_v  = 3'b000;
      penable = 1'b0;
      chk({name, "_after"}, 32'(outs(inst)), 32'h0);
   endtask

   task automatic xfer(input int inst, input logic [3:0] a, input logic w, input logic [15:0] d,
                       input string name, output logic [15:0] rd, output logic er, output int waits);
      bit done;
      done  = 1'b0;
      waits = 0;
      rd    = 16'h0;
      er    = 1'b0;
      @(negedge pclk);
      chk({name, "_setup_outs"}, 32'(outs(inst)), 32'h0);
      psel_v  = 3'(1 << inst);
      penable = 1'b0;
      paddr   = a;
      pwrite  = w;
      pwdata  = d;
      @(negedge pclk);
      penable = 1'b1;
      // Bus garbage during access must be ignored by the slave.
      paddr   = 4'($urandom);
      pwrite  = 1'($urandom);
      pwdata  = 16'($urandom);
      for (int c = 0; c < 40 && !done; c++) begin
         if (pready_w[inst]) begin
            rd   = prdata_w[inst];
            er   = pslverr_w[inst];
            done = 1'b1;
         end else begin
            waits++;
            @(negedge pclk);
         end
      end
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s_timeout: pready not seen in 40 cycles", name);
      end
   endtask

   task automatic run(input int inst, input logic [3:0] a, input logic w, input logic [15:0] d,
                      input logic [15:0] exp_rd, input logic exp_er, input int exp_wt,
                      input bit b2b, input string name);
      logic [15:0] rd;
      logic        er;
      int          wt;
      xfer(inst, a, w, d, name, rd, er, wt);
      chk({name, "_pslverr"}, 32'(er), 32'(exp_er));
      chk({name, "_waits"}, 32'(wt), 32'(exp_wt));
      if (!w) chk({name, "_prdata"}, 32'(rd), 32'(exp_rd));
      if (!b2b) idle_chk(inst, name);
   endtask

   initial begin
      logic [15:0] erd;
      logic        eer;
      int          inst;
      logic [3:0]  a;
      logic        w;
      logic [15:0] d;
      bit          b2b;

      preset  = 1'b1;
      psel_v  = 3'b000;
      penable = 1'b0;
      paddr   = 4'h0;
      pwrite  = 1'b0;
      pwdata  = 16'h0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 16; j++) mem[i][j] = 16'h0;

      repeat (3) @(negedge pclk);
      for (int i = 0; i < 3; i++) chk($sformatf("reset_outs%0d", i), 32'(outs(i)), 32'h0);
      preset = 1'b0;

      //          inst addr   w     wdata     rdata     err   wt b2b
      tbl[0]  = '{0, 4'hA, 1'b1, 16'hABAB, 16'h0000, 1'b0, 0, 1'b0};
      tbl[1]  = '{0, 4'hA, 1'b0, 16'h0000, 16'hABAB, 1'b0, 0, 1'b0};
      tbl[2]  = '{1, 4'h4, 1'b1, 16'h0066, 16'h0000, 1'b0, 2, 1'b0};
      tbl[3]  = '{1, 4'h4, 1'b0, 16'h0000, 16'h0066, 1'b0, 2, 1'b0};
      tbl[4]  = '{0, 4'hF, 1'b0, 16'h0000, 16'hA5B0, 1'b0, 0, 1'b0};
      tbl[5]  = '{0, 4'hF, 1'b1, 16'h1234, 16'h0000, 1'b1, 0, 1'b0};
      tbl[6]  = '{0, 4'hF, 1'b0, 16'h0000, 16'hA5B0, 1'b0, 0, 1'b0};
      tbl[7]  = '{0, 4'hD, 1'b0, 16'h0000, 16'h0000, 1'b1, 0, 1'b0};
      tbl[8]  = '{0, 4'hD, 1'b1, 16'h5555, 16'h0000, 1'b1, 0, 1'b0};
      tbl[9]  = '{0, 4'h1, 1'b1, 16'h0011, 16'h0000, 1'b0, 0, 1'b1};
      tbl[10] = '{0, 4'h2, 1'b1, 16'h0022, 16'h0000, 1'b0, 0, 1'b0};
      tbl[11] = '{0, 4'h1, 1'b0, 16'h0000, 16'h0011, 1'b0, 0, 1'b1};
      tbl[12] = '{0, 4'h2, 1'b0, 16'h0000, 16'h0022, 1'b0, 0, 1'b0};
      tbl[13] = '{2, 4'h0, 1'b0, 16'h0000, 16'h0000, 1'b0, 3, 1'b0};
      tbl[14] = '{0, 4'hC, 1'b0, 16'h0000, 16'h0000, 1'b1, 0, 1'b0};
      tbl[15] = '{0, 4'hB, 1'b1, 16'hFFFF, 16'h0000, 1'b0, 0, 1'b0};
      tbl[16] = '{0, 4'hB, 1'b0, 16'h0000, 16'hFFFF, 1'b0, 0, 1'b0};
      tbl[17] = '{0, 4'h4, 1'b0, 16'h0000, 16'h0000, 1'b0, 0, 1'b0};

      for (int i = 0; i < 18; i++)
         run(tbl[i].inst, tbl[i].a, tbl[i].w, tbl[i].d, tbl[i].rd, tbl[i].er, tbl[i].wt,
             tbl[i].b2b, $sformatf("vec%0d", i));

      // penable without a preceding setup must be ignored.
      @(negedge pclk);
      psel_v  = 3'b001;
      penable = 1'b1;
      paddr   = 4'hA;
      pwrite  = 1'b1;
      pwdata  = 16'hDEAD;
      repeat (3) begin
         @(negedge pclk);
         chk("noset_pready", 32'(pready_w[0]), 32'h0);
      end
      psel_v  = 3'b000;
      penable = 1'b0;
      run(0, 4'hA, 1'b0, 16'h0, 16'hABAB, 1'b0, 0, 1'b0, "noset_rd");

      // Abort in WAIT on the 3-wait instance.
      @(negedge pclk);
      psel_v  = 3'b100;
      penable = 1'b0;
      paddr   = 4'h3;
      pwrite  = 1'b1;
      pwdata  = 16'hDEAD;
      @(negedge pclk);
      penable = 1'b1;
      chk("abort_acc1", 32'(pready_w[2]), 32'h0);
      @(negedge pclk);
      chk("abort_acc2", 32'(pready_w[2]), 32'h0);
      @(negedge pclk);
      chk("abort_acc3", 32'(pready_w[2]), 32'h0);
      psel_v  = 3'b000;
      penable = 1'b0;
      repeat (4) begin
         @(negedge pclk);
         chk("abort_after", 32'(outs(2)), 32'h0);
      end
      run(2, 4'h3, 1'b0, 16'h0, 16'h0000, 1'b0, 3, 1'b0, "abort_rd");
      run(2, 4'h3, 1'b1, 16'h3333, 16'h0000, 1'b0, 3, 1'b0, "abort_wr2");
      run(2, 4'h3, 1'b0, 16'h0, 16'h3333, 1'b0, 3, 1'b0, "abort_rd2");

      // Reset during the READY cycle of a write.
      @(negedge pclk);
      psel_v  = 3'b001;
      penable = 1'b0;
      paddr   = 4'h5;
      pwrite  = 1'b1;
      pwdata  = 16'hBEEF;
      @(negedge pclk);
      penable = 1'b1;
      chk("rst_ready", 32'(pready_w[0]), 32'h1);
      preset = 1'b1;
      @(negedge pclk);
      chk("rst_outs", 32'(outs(0)), 32'h0);
      preset  = 1'b0;
      psel_v  = 3'b000;
      penable = 1'b0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 16; j++) mem[i][j] = 16'h0;
      run(0, 4'h5, 1'b0, 16'h0, 16'h0000, 1'b0, 0, 1'b0, "rst_r5");
      run(0, 4'hA, 1'b0, 16'h0, 16'h0000, 1'b0, 0, 1'b0, "rst_rA");
      run(0, 4'h1, 1'b0, 16'h0, 16'h0000, 1'b0, 0, 1'b0, "rst_r1");
      run(0, 4'hB, 1'b0, 16'h0, 16'h0000, 1'b0, 0, 1'b0, "rst_rB");
      run(1, 4'h4, 1'b0, 16'h0, 16'h0000, 1'b0, 2, 1'b0, "rst_i1r4");
      run(2, 4'h3, 1'b0, 16'h0, 16'h0000, 1'b0, 3, 1'b0, "rst_i2r3");

      // Random traffic against the reference model.
      for (int i = 0; i < 300; i++) begin
         inst = int'($urandom_range(0, 2));
         a    = 4'($urandom_range(0, 15));
         w    = 1'($urandom);
         d    = 16'($urandom);
         b2b  = ($urandom_range(0, 3) == 0);
         model_xfer(inst, a, w, d, erd, eer);
         run(inst, a, w, d, erd, eer, wait_of(inst), b2b, $sformatf("rnd%0d", i));
      end

      idle_chk(0, "final");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
